cpu_program_loader: RTL

Byte-stream front end that fills the single-cycle CPU's instruction and data memories through its load port (address, inst_data, write_instruction, write_data) and sequences its reset. It holds the CPU in reset while loading. It accepts framed load packets on a valid/ready byte interface, assembles big-endian 32-bit words, and issues one write strobe per word. A RUN command releases the CPU and a HALT command stops it again.

---
 rtl/cpu_program_loader.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/cpu_program_loader.sv
// Byte-stream loader for the single-cycle CPU: framed load packets -> instruction/data
// memory writes, plus RUN/HALT control of the CPU reset. Optional trailer: LOADER_CHECKSUM_EN.
module cpu_program_loader #(
   parameter int unsigned ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              cpu_rst,
   output logic [ADDR_W-1:0] address,
   output logic [31:0]       inst_data,
   output logic              write_instruction,
   output logic              write_data,
   output logic              busy,
   output logic              err
);

   typedef enum logic [2:0] {
      S_CMD,
      S_HDR,
      S_WORD,
      S_WRITE,
`ifdef LOADER_CHECKSUM_EN
      S_CSUM,
`endif
      S_RUN
   } state_t;

   state_t              r_state;
   state_t              w_next;
   state_t              w_end_state;
   logic [1:0]          r_byte_cnt;
   logic                r_region;
   logic [15:0]         r_remaining;
   logic [ADDR_W-1:0]   r_addr;
   logic [31:0]         r_word;
   logic                r_cpu_rst;
   logic                r_err;
   logic                w_ready;
   logic                w_xfer;
   logic                w_last_byte;
   logic                w_run_ok;

`ifdef LOADER_CHECKSUM_EN
   logic [7:0]          r_csum;
   logic                r_lock;

   assign w_end_state = S_CSUM;
   assign w_run_ok    = !r_lock;
`else
   assign w_end_state = S_CMD;
   assign w_run_ok    = 1'b1;
`endif

   assign w_ready     = !rst && (r_state != S_WRITE);
   assign w_xfer      = in_valid && w_ready;
   assign w_last_byte = (r_byte_cnt == 2'd3);

   assign in_ready  = w_ready;
   assign cpu_rst   = r_cpu_rst;
   assign address   = r_addr;
   assign inst_data = r_word;
   assign err       = r_err;

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_CMD;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next            = r_state;
      busy              = 1'b0;
      write_instruction = 1'b0;
      write_data        = 1'b0;
      if (!rst) begin
         busy              = (r_state != S_CMD) && (r_state != S_RUN);
         write_instruction = (r_state == S_WRITE) && !r_region;
         write_data        = (r_state == S_WRITE) &&  r_region;
      end
      case (r_state)
         S_CMD: begin
            if (w_xfer) begin
               if (in_data == 8'h01 || in_data == 8'h02)  w_next = S_HDR;
               else if (in_data == 8'h03 && w_run_ok)     w_next = S_RUN;
            end
         end
         S_HDR: begin
            // count is {byte2, byte3}; byte2 already sits in r_remaining[7:0]
            if (w_xfer && w_last_byte)
               w_next = ({r_remaining[7:0], in_data} == 16'd0) ? w_end_state : S_WORD;
         end
         S_WORD: begin
            if (w_xfer && w_last_byte) w_next = S_WRITE;
         end
         S_WRITE: begin
            w_next = (r_remaining == 16'd1) ? w_end_state : S_WORD;
         end
`ifdef LOADER_CHECKSUM_EN
         S_CSUM: begin
            if (w_xfer) w_next = S_CMD;
         end
`endif
         S_RUN: begin
            if (w_xfer && in_data == 8'h04) w_next = S_CMD;
         end
         default: w_next = S_CMD;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_byte_cnt  <= '0;
         r_region    <= 1'b0;
         r_remaining <= '0;
         r_addr      <= '0;
         r_word      <= '0;
         r_cpu_rst   <= 1'b1;
         r_err       <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
         r_csum      <= '0;
         r_lock      <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_CMD: begin
               if (w_xfer) begin
                  r_byte_cnt <= '0;
                  case (in_data)
                     8'h01, 8'h02: begin
                        r_region <= in_data[1];
`ifdef LOADER_CHECKSUM_EN
                        r_csum   <= '0;
`endif
                     end
                     8'h03:   if (w_run_ok) r_cpu_rst <= 1'b0;
                     8'h04:   ;
                     default: r_err <= 1'b1;
                  endcase
               end
            end
            S_HDR: begin
               if (w_xfer) begin
                  r_byte_cnt <= r_byte_cnt + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                  r_csum     <= r_csum ^ in_data;
`endif
                  // address bytes shift straight into the address register, keeping the low ADDR_W bits
                  if (!r_byte_cnt[1]) r_addr      <= ADDR_W'({r_addr, in_data});
                  else                r_remaining <= {r_remaining[7:0], in_data};
               end
            end
            S_WORD: begin
               if (w_xfer) begin
                  r_byte_cnt <= r_byte_cnt + 2'd1;
                  r_word     <= {r_word[23:0], in_data};
`ifdef LOADER_CHECKSUM_EN
                  r_csum     <= r_csum ^ in_data;
`endif
               end
            end
            S_WRITE: begin
               r_addr      <= r_addr + ADDR_W'(1);
               r_remaining <= r_remaining - 16'd1;
            end
`ifdef LOADER_CHECKSUM_EN
            S_CSUM: begin
               if (w_xfer && in_data != r_csum) begin
                  r_err  <= 1'b1;
                  r_lock <= 1'b1;
               end
            end
`endif
            S_RUN: begin
               if (w_xfer && in_data == 8'h04) r_cpu_rst <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule
